// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// Opcodes, FSM states, mux selects and the control bundle.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bundle: opcode/mem_ready in, control out.
// master = controller side, slave = datapath side.
interface mc_main_ctrl_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               ir_write;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic [STATE_W-1:0] state;
  logic               instr_done;
  logic               illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord,
    output mem_read, mem_write, mem_to_reg,
    output ir_write, reg_dst, reg_write,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, state,
    output instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord,
    input  mem_read, mem_write, mem_to_reg,
    input  ir_write, reg_dst, reg_write,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, state,
    input  instr_done, illegal_op
  );
endinterface

// File: rtl/mc_main_ctrl_outdec.sv
// Moore control decode: state (+ gated mem_ready) -> control bundle.
// HALT and unused codes fall through to all-zero.
module mc_ctrl_outdec
  import mips_mc_pkg::*;
(
  input  state_t st,
  input  logic   ready,
  output ctrl_t  ctl
);

  always_comb begin
    ctl = '0;
    unique case (st)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ALU_SRC_B_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.ir_write  = ready;
        ctl.pc_write  = ready;
      end
      S_DECODE: ctl.alu_src_b = ALU_SRC_B_IMMSH;
      S_MEM_ADDR, S_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALU_SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = ready;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PC_SRC_ALUOUT;
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PC_SRC_JUMP;
        ctl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: state register and next-state logic.
// Output decode lives in mc_ctrl_outdec.
module mc_main_ctrl
  import mips_mc_pkg::*;
#(
  parameter int STATE_W         = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input logic            clk,
  input logic            rst,
  mc_main_ctrl_if.master bus
);

  state_t st, nxt;
  ctrl_t  ctl;
  logic   ready;

  // rst forces FETCH, so masking ready kills its write enables
  assign ready = bus.mem_ready & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_FETCH;
    else     st <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    unique case (st)
      S_FETCH:    nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          bus.opcode == OP_RTYPE: nxt = S_R_EXEC;
          bus.opcode == OP_LW,
          bus.opcode == OP_SW:    nxt = S_MEM_ADDR;
          bus.opcode == OP_BEQ:   nxt = S_BRANCH;
          bus.opcode == OP_J:     nxt = S_JUMP;
          bus.opcode == OP_ADDI:  nxt = S_ADDI_EX;
          default: nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   nxt = S_R_WB;
      S_ADDI_EX:  nxt = S_ADDI_WB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .st    (st),
    .ready (ready),
    .ctl   (ctl)
  );

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.iord          = ctl.iord;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.instr_done    = ctl.instr_done;
  assign bus.state         = STATE_W'(st);
  assign bus.illegal_op    = (st == S_DECODE)
                           & ~is_legal_op(bus.opcode);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: per-cycle expected state/controls.
// Two DUTs share stimulus; the second parks in HALT on illegal opcodes.
module tb_mc_main_ctrl;
  import mips_mc_pkg::*;

  // {pcw,pcc,iord,mr,mw,m2r,irw,rdst,rw,asa,asb[2],aop[2],pcs[2],done,ill}
  localparam logic [17:0] E_FW   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FR   = 18'b1_0_0_1_0_0_1_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_DILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] E_MA   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWB  = 18'b0_0_0_0_0_1_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MWW  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MWD  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_REX  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] E_RWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] E_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] E_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] E_AWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [5:0]  OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  always #5 clk = ~clk;

  mc_main_ctrl_if #(.STATE_W(4)) bus1 ();
  mc_main_ctrl_if #(.STATE_W(4)) bus2 ();

  assign bus1.opcode    = opcode;
  assign bus1.mem_ready = mem_ready;
  assign bus2.opcode    = opcode;
  assign bus2.mem_ready = mem_ready;

  mc_main_ctrl #(.STATE_W(4), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mc_main_ctrl #(.STATE_W(4), .HALT_ON_ILLEGAL(1'b1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [17:0] o1;
  assign o1 = {bus1.pc_write, bus1.pc_write_cond, bus1.iord,
               bus1.mem_read, bus1.mem_write, bus1.mem_to_reg,
               bus1.ir_write, bus1.reg_dst, bus1.reg_write,
               bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op,
               bus1.pc_source, bus1.instr_done, bus1.illegal_op};

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] ctl;
    int          s2;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  string tname  = "init";

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".state"}, 32'(bus1.state), 32'(e.st));
      chk({e.tag, ".ctl"}, 32'(o1), 32'(e.ctl));
      if (e.s2 >= 0)
        chk({e.tag, ".halt_state"}, 32'(bus2.state), 32'(e.s2));
    end
  end

  task automatic step(logic [5:0] op, logic rdy, logic [3:0] st,
                      logic [17:0] ctl, int s2 = -1);
    exp_t e;
    opcode    = op;
    mem_ready = rdy;
    e.tag = tname;
    e.st  = st;
    e.ctl = ctl;
    e.s2  = s2;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(OP_LW, 1'b1, 4'd0, E_FW, 0);
    step(OP_LW, 1'b1, 4'd0, E_FW, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    tname = "reset";
    do_reset();

    tname = "lw";
    step(OP_LW, 1'b1, 4'd0, E_FR);
    step(OP_LW, 1'b1, 4'd1, E_DEC);
    step(OP_LW, 1'b1, 4'd2, E_MA);
    step(OP_LW, 1'b1, 4'd3, E_MRD);
    step(OP_LW, 1'b1, 4'd4, E_MWB);

    tname = "lw_stall";
    step(OP_LW, 1'b1, 4'd0, E_FR);
    step(OP_LW, 1'b1, 4'd1, E_DEC);
    step(OP_LW, 1'b1, 4'd2, E_MA);
    step(OP_LW, 1'b0, 4'd3, E_MRD);
    step(OP_LW, 1'b1, 4'd3, E_MRD);
    step(OP_LW, 1'b1, 4'd4, E_MWB);

    tname = "sw_stall";
    step(OP_SW, 1'b1, 4'd0, E_FR);
    step(OP_SW, 1'b1, 4'd1, E_DEC);
    step(OP_SW, 1'b1, 4'd2, E_MA);
    for (int i = 0; i < 3; i++)
      step(OP_SW, 1'b0, 4'd5, E_MWW);
    step(OP_SW, 1'b1, 4'd5, E_MWD);

    tname = "rtype";
    step(OP_RTYPE, 1'b1, 4'd0, E_FR);
    step(OP_RTYPE, 1'b1, 4'd1, E_DEC);
    step(OP_RTYPE, 1'b1, 4'd6, E_REX);
    step(OP_RTYPE, 1'b1, 4'd7, E_RWB);

    tname = "beq";
    step(OP_BEQ, 1'b1, 4'd0, E_FR);
    step(OP_BEQ, 1'b1, 4'd1, E_DEC);
    step(OP_BEQ, 1'b1, 4'd8, E_BR);

    tname = "addi";
    step(OP_ADDI, 1'b1, 4'd0, E_FR);
    step(OP_ADDI, 1'b1, 4'd1, E_DEC);
    step(OP_ADDI, 1'b1, 4'd10, E_MA);
    step(OP_ADDI, 1'b1, 4'd11, E_AWB);

    tname = "fetch_stall_j";
    step(OP_J, 1'b0, 4'd0, E_FW);
    step(OP_J, 1'b0, 4'd0, E_FW);
    step(OP_J, 1'b1, 4'd0, E_FR);
    step(OP_J, 1'b1, 4'd1, E_DEC);
    step(OP_J, 1'b1, 4'd9, E_JMP);

    tname = "illegal";
    step(OP_BAD, 1'b1, 4'd0, E_FR, 0);
    step(OP_BAD, 1'b1, 4'd1, E_DILL, 1);
    step(OP_BAD, 1'b0, 4'd0, E_FW, 15);
    step(OP_BAD, 1'b0, 4'd0, E_FW, 15);
    step(OP_BAD, 1'b1, 4'd0, E_FR, 15);
    step(OP_J, 1'b1, 4'd1, E_DEC, 15);
    step(OP_J, 1'b1, 4'd9, E_JMP, 15);

    tname = "halt_reset";
    do_reset();

    tname = "async_rst";
    step(OP_SW, 1'b1, 4'd0, E_FR, 0);
    step(OP_SW, 1'b1, 4'd1, E_DEC, 1);
    step(OP_SW, 1'b1, 4'd2, E_MA, 2);
    step(OP_SW, 1'b0, 4'd5, E_MWW, 5);
    #2;
    rst = 1'b1;
    step(OP_SW, 1'b0, 4'd0, E_FW, 0);
    rst = 1'b0;
    tname = "post_rst";
    step(OP_SW, 1'b0, 4'd0, E_FW, 0);
    step(OP_SW, 1'b1, 4'd0, E_FR, 0);
    step(OP_SW, 1'b1, 4'd1, E_DEC, 1);
    step(OP_SW, 1'b1, 4'd2, E_MA, 2);
    step(OP_SW, 1'b1, 4'd5, E_MWD, 5);
    step(OP_SW, 1'b0, 4'd0, E_FW, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
